// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The state encoding is used by the top; the lane constant is used by the byte packer.
package imem_program_loader_pkg;

  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Byte address of word number 'words' above 'base'; wraps modulo 2^64.
  function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [15:0] words);
    return base + {46'd0, words, 2'b00};
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream, instruction-memory write and core-control signals of the program loader.
// 'master' is the loader side, 'slave' is the environment (stream source, imem, core).
interface imem_program_loader_if;

  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_resetl;
  logic [63:0] startpc;
  logic [15:0] loaded_words;
  logic        done;
  logic        error;

  modport master (
    input  start, in_valid, in_data, in_last,
    output in_ready, imem_we, imem_waddr, imem_wdata,
    output core_resetl, startpc, loaded_words, done, error
  );

  modport slave (
    output start, in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_waddr, imem_wdata,
    input  core_resetl, startpc, loaded_words, done, error
  );

endinterface

// File: rtl/imem_program_loader_byte_packer.sv
// Collects bytes little-endian into a 32-bit word; word_o already includes the byte
// being pushed, so the word can be captured on the same edge that completes it.
module imem_program_loader_byte_packer
  import imem_program_loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [7:0]           byte_i,
  output logic                 word_full_o,
  output logic [8*LANES-1:0]   word_o
);

  logic [LANE_IDX_W-1:0] idx_q, idx_d;
  logic [8*LANES-1:0]    lanes_q, lanes_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (push_i) begin
      idx_d = idx_q + LANE_IDX_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes_d[gi*8 +: 8] = clear_i ? 8'h00 :
                                  (push_i && idx_q == LANE_IDX_W'(gi)) ? byte_i :
                                  lanes_q[gi*8 +: 8];
    end
  endgenerate

  assign word_full_o = push_i && (idx_q == LANE_IDX_W'(LANES - 1));
  assign word_o      = lanes_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a byte-streamed program into instruction memory from START_PC upward and holds the
// core in reset until the last word has been written plus HOLD_CYCLES settling cycles.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter logic [63:0] START_PC    = 64'h0,
  parameter int          DEPTH_WORDS = 256,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   resetl,
  imem_program_loader_if.master  bus
);

  localparam int          HOLD_W  = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_e              state_q, state_d;
  logic [15:0]         words_q, words_d;
  logic                last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [63:0]         waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                xfer;
  logic                start_ok;
  logic                word_full;
  logic [31:0]         word;

  assign xfer     = bus.in_valid && (state_q == ST_LOAD);
  assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

  imem_program_loader_byte_packer u_packer (
    .clk_i       (CLK),
    .rst_i       (resetl),
    .clear_i     (start_ok),
    .push_i      (xfer),
    .byte_i      (bus.in_data),
    .word_full_o (word_full),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    last_d  = last_q;
    hold_d  = hold_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          words_d = '0;
          last_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (word_full) begin
            // A word beyond capacity is rejected before it ever reaches the memory.
            if ({1'b0, words_q} >= DEPTH_L) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_WRITE;
              waddr_d = word_addr(START_PC, words_q);
              wdata_d = word;
              last_d  = bus.in_last;
            end
          end else if (bus.in_last) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_WRITE: begin
        words_d = words_q + 16'd1;
        if (last_q) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      last_q  <= 1'b0;
      hold_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_LOAD);
  assign bus.imem_we      = (state_q == ST_WRITE);
  assign bus.imem_waddr   = waddr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.core_resetl  = (state_q == ST_DONE);
  assign bus.startpc      = START_PC;
  assign bus.loaded_words = words_q;
  assign bus.done         = (state_q == ST_DONE);
  assign bus.error        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the program loader: a small-capacity loader at address 0 and a second
// loader at the top of the address space share the same byte stream.
module tb_imem_program_loader;

  localparam logic [63:0] PC0     = 64'h0;
  localparam logic [63:0] PC_WRAP = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          DEPTH   = 16;
  localparam int          HOLD    = 2;

  logic CLK = 1'b0;
  logic resetl;
  always #5 CLK = ~CLK;

  imem_program_loader_if bus ();
  imem_program_loader_if bus2 ();

  assign bus2.start    = bus.start;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_data  = bus.in_data;
  assign bus2.in_last  = bus.in_last;

  imem_program_loader #(.START_PC(PC0), .DEPTH_WORDS(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .resetl(resetl), .bus(bus)
  );

  imem_program_loader #(.START_PC(PC_WRAP), .DEPTH_WORDS(256), .HOLD_CYCLES(HOLD)) dut_wrap (
    .CLK(CLK), .resetl(resetl), .bus(bus2)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_cyc = 0;
  int          rise_cyc = 0;
  int          ready_viol = 0;
  logic        crl_prev = 1'b0;
  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [63:0] wa2_q[$];
  logic [31:0] wd2_q[$];
  logic [7:0]  stim [0:127];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.imem_we) begin
      wa_q.push_back(bus.imem_waddr);
      wd_q.push_back(bus.imem_wdata);
      we_cyc <= cyc;
      if (bus.in_ready) ready_viol <= ready_viol + 1;
      $display("[%0t] write addr=%h data=%h", $time, bus.imem_waddr, bus.imem_wdata);
    end
    if (bus2.imem_we) begin
      wa2_q.push_back(bus2.imem_waddr);
      wd2_q.push_back(bus2.imem_wdata);
    end
    if (bus.core_resetl && !crl_prev) rise_cyc <= cyc;
    crl_prev <= bus.core_resetl;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  // Presents one byte from a negedge and returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input logic last, input bit rnd);
    int n = 0;
    if (rnd) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check_val("ready_wait", 64'(n), 64'd0);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_range(input int nbytes, input bit mark_last, input bit rnd);
    for (int i = 0; i < nbytes; i++)
      send_byte(stim[i], mark_last && (i == nbytes - 1), rnd);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!bus.done && !bus.error && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check_val("end_wait", 64'(n), 64'd0);
    @(negedge CLK);
  endtask

  task automatic fill_prog1();
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h80; stim[3] = 8'hD2;
    stim[4] = 8'h21; stim[5] = 8'h04; stim[6] = 8'h00; stim[7] = 8'h91;
  endtask

  task automatic fill_words(input int nwords);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = 32'hC0DE_0000 + 32'(i);
      for (int k = 0; k < 4; k++) stim[i*4 + k] = w[8*k +: 8];
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_in_ready"},     64'(bus.in_ready),     64'd0);
    check_val({pfx, "_imem_we"},      64'(bus.imem_we),      64'd0);
    check_val({pfx, "_imem_waddr"},   bus.imem_waddr,        64'd0);
    check_val({pfx, "_imem_wdata"},   64'(bus.imem_wdata),   64'd0);
    check_val({pfx, "_core_resetl"},  64'(bus.core_resetl),  64'd0);
    check_val({pfx, "_loaded_words"}, 64'(bus.loaded_words), 64'd0);
    check_val({pfx, "_done"},         64'(bus.done),         64'd0);
    check_val({pfx, "_error"},        64'(bus.error),        64'd0);
  endtask

  initial begin
    int base;
    int base2;
    resetl       = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    check_val("startpc", bus.startpc, PC0);

    // Stream bytes while idle: nothing may be taken.
    resetl       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (3) @(negedge CLK);
    bus.in_valid = 1'b0;
    check_val("idle_loaded_words", 64'(bus.loaded_words), 64'd0);
    check_val("idle_in_ready",     64'(bus.in_ready),     64'd0);

    // Two-word program, back-to-back bytes.
    base  = wa_q.size();
    base2 = wa2_q.size();
    pulse_start();
    fill_prog1();
    send_range(8, 1'b1, 1'b0);
    wait_end();
    check_val("t1_nwrites", 64'(wa_q.size() - base), 64'd2);
    if (wa_q.size() - base == 2) begin
      check_val("t1_addr0", wa_q[base],       PC0);
      check_val("t1_data0", 64'(wd_q[base]),  64'hD280_0013);
      check_val("t1_addr1", wa_q[base+1],     PC0 + 64'd4);
      check_val("t1_data1", 64'(wd_q[base+1]), 64'h9100_0421);
    end
    check_val("t1_loaded_words", 64'(bus.loaded_words), 64'd2);
    check_val("t1_done",         64'(bus.done),         64'd1);
    check_val("t1_core_resetl",  64'(bus.core_resetl),  64'd1);
    // Strobe seen in cycle N; core released HOLD cycles after the strobe drops.
    check_val("t1_release_delay", 64'(rise_cyc - we_cyc), 64'(HOLD + 1));

    // Same stream into the loader based at the top of the address space.
    check_val("t6_nwrites", 64'(wa2_q.size() - base2), 64'd2);
    if (wa2_q.size() - base2 == 2) begin
      check_val("t6_addr0", wa2_q[base2],       64'hFFFF_FFFF_FFFF_FFFC);
      check_val("t6_addr1", wa2_q[base2+1],     64'h0);
      check_val("t6_data1", 64'(wd2_q[base2+1]), 64'h9100_0421);
    end
    check_val("t6_startpc", bus2.startpc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("t6_done",    64'(bus2.done), 64'd1);

    // Misaligned last on byte 6.
    base = wa_q.size();
    pulse_start();
    check_val("t2_done_cleared", 64'(bus.done),        64'd0);
    check_val("t2_crl_cleared",  64'(bus.core_resetl), 64'd0);
    send_range(6, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    check_val("t2_error",       64'(bus.error),         64'd1);
    check_val("t2_core_resetl", 64'(bus.core_resetl),   64'd0);
    check_val("t2_nwrites",     64'(wa_q.size() - base), 64'd1);
    base = wa_q.size();
    pulse_start();
    check_val("t2_error_cleared", 64'(bus.error), 64'd0);
    stim[0] = 8'h78; stim[1] = 8'h56; stim[2] = 8'h34; stim[3] = 8'h12;
    send_range(4, 1'b1, 1'b0);
    wait_end();
    check_val("t2_done", 64'(bus.done), 64'd1);
    check_val("t2_good_nwrites", 64'(wa_q.size() - base), 64'd1);
    if (wa_q.size() - base == 1) begin
      check_val("t2_good_addr", wa_q[base],      PC0);
      check_val("t2_good_data", 64'(wd_q[base]), 64'h1234_5678);
    end

    // Exactly full memory is legal.
    base = wa_q.size();
    pulse_start();
    fill_words(DEPTH);
    send_range(DEPTH * 4, 1'b1, 1'b0);
    wait_end();
    check_val("t3_full_done",   64'(bus.done),          64'd1);
    check_val("t3_full_words",  64'(bus.loaded_words),  64'(DEPTH));
    check_val("t3_full_writes", 64'(wa_q.size() - base), 64'(DEPTH));
    if (wa_q.size() - base == DEPTH) begin
      check_val("t3_last_addr", wa_q[base+DEPTH-1],      64'((DEPTH - 1) * 4));
      check_val("t3_last_data", 64'(wd_q[base+DEPTH-1]), 64'(32'hC0DE_0000 + 32'(DEPTH - 1)));
    end

    // One word too many.
    base = wa_q.size();
    pulse_start();
    fill_words(DEPTH + 1);
    send_range((DEPTH + 1) * 4, 1'b1, 1'b0);
    wait_end();
    check_val("t3_over_error",  64'(bus.error),          64'd1);
    check_val("t3_over_done",   64'(bus.done),           64'd0);
    check_val("t3_over_writes", 64'(wa_q.size() - base), 64'(DEPTH));
    check_val("t3_over_words",  64'(bus.loaded_words),   64'(DEPTH));

    // Gapped and back-to-back valid must give the same writes as the first load.
    base = wa_q.size();
    pulse_start();
    fill_prog1();
    send_range(8, 1'b1, 1'b1);
    wait_end();
    check_val("t4_done",    64'(bus.done),          64'd1);
    check_val("t4_nwrites", 64'(wa_q.size() - base), 64'd2);
    if (wa_q.size() - base == 2) begin
      check_val("t4_addr0", wa_q[base],        PC0);
      check_val("t4_data0", 64'(wd_q[base]),   64'hD280_0013);
      check_val("t4_addr1", wa_q[base+1],      PC0 + 64'd4);
      check_val("t4_data1", 64'(wd_q[base+1]), 64'h9100_0421);
    end
    check_val("t4_ready_during_write", 64'(ready_viol), 64'd0);

    // Reset after two bytes of the third word.
    pulse_start();
    fill_prog1();
    stim[8] = 8'hAA; stim[9] = 8'hBB;
    send_range(10, 1'b0, 1'b0);
    check_val("t5_pre_words", 64'(bus.loaded_words), 64'd2);
    resetl = 1'b1;
    @(negedge CLK);
    check_reset_outputs("t5_reset");
    resetl = 1'b0;
    base = wa_q.size();
    pulse_start();
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    send_range(4, 1'b1, 1'b0);
    wait_end();
    check_val("t5_done",    64'(bus.done),          64'd1);
    check_val("t5_nwrites", 64'(wa_q.size() - base), 64'd1);
    if (wa_q.size() - base == 1) begin
      check_val("t5_addr", wa_q[base],      PC0);
      check_val("t5_data", 64'(wd_q[base]), 64'hDEAD_BEEF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
